// File: rtl/mem_latency_ctrl.sv
// Register-file memory with one write port and one read port; reads return after a LATENCY-stage pipeline.
// Optional: define MEM_CLEAR_ON_RESET_EN to zero every word of the array on the reset edge.
module mem_latency_ctrl #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_enable,
    input  logic              read_enable,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic [WIDTH-1:0]  write_data,
    output logic              mem_ready,
    output logic [WIDTH-1:0]  read_data
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wrInRange;
    logic             rdInRange;

    // DEPTH need not be a power of two, so addresses past the end must be filtered.
    assign wrInRange = ({1'b0, write_addr} < DEPTH_C);
    assign rdInRange = ({1'b0, read_addr} < DEPTH_C);

`ifdef MEM_CLEAR_ON_RESET_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_enable && wrInRange) begin
            mem[write_addr] <= write_data;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst && write_enable && wrInRange) begin
            mem[write_addr] <= write_data;
        end
    end
`endif

    if (LATENCY == 0) begin : gComb
        assign mem_ready = read_enable && !rst;
        assign read_data = (rst || !rdInRange) ? '0 : mem[read_addr];
    end else begin : gPipe
        logic [WIDTH-1:0] captureData;
        logic             lastValid;
        logic [WIDTH-1:0] lastData;
        logic             memReady_q;
        logic [WIDTH-1:0] readData_q;

        // A same-address write bypasses the array so the read sees the new value.
        always_comb begin
            captureData = '0;
            if (write_enable && wrInRange && (write_addr == read_addr)) begin
                captureData = write_data;
            end else if (rdInRange) begin
                captureData = mem[read_addr];
            end
        end

        if (LATENCY == 1) begin : gDirect
            assign lastValid = read_enable;
            assign lastData  = captureData;
        end else begin : gStages
            logic [LATENCY-2:0] pipeValid_q;
            logic [WIDTH-1:0]   pipeData_q [LATENCY-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    pipeValid_q <= '0;
                end else begin
                    pipeValid_q[0] <= read_enable;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pipeValid_q[i] <= pipeValid_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                pipeData_q[0] <= captureData;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pipeData_q[i] <= pipeData_q[i-1];
                end
            end

            assign lastValid = pipeValid_q[LATENCY-2];
            assign lastData  = pipeData_q[LATENCY-2];
        end

        // read_data holds its value through idle cycles; only a completing read reloads it.
        always_ff @(posedge clk) begin
            if (rst) begin
                memReady_q <= 1'b0;
                readData_q <= '0;
            end else begin
                memReady_q <= lastValid;
                if (lastValid) begin
                    readData_q <= lastData;
                end
            end
        end

        assign mem_ready = memReady_q;
        assign read_data = readData_q;
    end

endmodule

// File: tb/tb_mem_latency_ctrl.sv
// Directed bench for mem_latency_ctrl: three instances (LATENCY=1, LATENCY=3, DEPTH=12) share one stimulus stream.
module tb_mem_latency_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        writeEnable;
    logic        readEnable;
    logic [3:0]  writeAddr;
    logic [3:0]  readAddr;
    logic [31:0] writeData;
    logic        ready1, ready3, readyOdd;
    logic [31:0] data1, data3, dataOdd;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    mem_latency_ctrl #(.DEPTH(16), .WIDTH(32), .LATENCY(1)) dutL1 (
        .clk(clk), .rst(rst), .write_enable(writeEnable), .read_enable(readEnable),
        .write_addr(writeAddr), .read_addr(readAddr), .write_data(writeData),
        .mem_ready(ready1), .read_data(data1));

    mem_latency_ctrl #(.DEPTH(16), .WIDTH(32), .LATENCY(3)) dutL3 (
        .clk(clk), .rst(rst), .write_enable(writeEnable), .read_enable(readEnable),
        .write_addr(writeAddr), .read_addr(readAddr), .write_data(writeData),
        .mem_ready(ready3), .read_data(data3));

    mem_latency_ctrl #(.DEPTH(12), .WIDTH(32), .LATENCY(1)) dutOdd (
        .clk(clk), .rst(rst), .write_enable(writeEnable), .read_enable(readEnable),
        .write_addr(writeAddr), .read_addr(readAddr), .write_data(writeData),
        .mem_ready(readyOdd), .read_data(dataOdd));

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then let the edge pass so outputs can be sampled 1 ns later.
    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                 input logic re, input logic [3:0] ra);
        writeEnable = we;
        writeAddr   = wa;
        writeData   = wd;
        readEnable  = re;
        readAddr    = ra;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] expMem [16];
    logic [31:0] afterReset;
    int          head, tail, count;
    logic        doPush, doPop;
    logic [31:0] pushData, popExpect;

    initial begin
        rst = 1'b1;
        writeEnable = 1'b0; readEnable = 1'b0;
        writeAddr = '0; readAddr = '0; writeData = '0;

        // Reset held with reads requested: nothing may emerge.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd0);
            checkOutput("rst_ready1", {31'd0, ready1}, 32'd0);
            checkOutput("rst_data1", data1, 32'd0);
            checkOutput("rst_ready3", {31'd0, ready3}, 32'd0);
            checkOutput("rst_data3", data3, 32'd0);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        checkOutput("postrst_ready1", {31'd0, ready1}, 32'd0);
        checkOutput("postrst_data1", data1, 32'd0);

        // Basic LATENCY=1 read and hold.
        applyStimulus(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd3);
        checkOutput("basic_ready", {31'd0, ready1}, 32'd1);
        checkOutput("basic_data", data1, 32'hDEADBEEF);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        checkOutput("idle_ready", {31'd0, ready1}, 32'd0);
        checkOutput("idle_hold", data1, 32'hDEADBEEF);

        // Write-first collision, seen on both latencies.
        applyStimulus(1'b1, 4'd5, 32'h12345678, 1'b1, 4'd5);
        checkOutput("coll_ready1", {31'd0, ready1}, 32'd1);
        checkOutput("coll_data1", data1, 32'h12345678);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        checkOutput("coll_early3", {31'd0, ready3}, 32'd0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        checkOutput("coll_ready3", {31'd0, ready3}, 32'd1);
        checkOutput("coll_data3", data3, 32'h12345678);

        // Out-of-range addresses on the 12-deep instance.
        applyStimulus(1'b1, 4'd13, 32'hAAAA5555, 1'b0, 4'd0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd13);
        checkOutput("oor_data16", data1, 32'hAAAA5555);
        checkOutput("oor_ready12", {31'd0, readyOdd}, 32'd1);
        checkOutput("oor_data12", dataOdd, 32'd0);
        applyStimulus(1'b1, 4'd14, 32'h00000077, 1'b1, 4'd14);
        checkOutput("oorcoll_data16", data1, 32'h00000077);
        checkOutput("oorcoll_data12", dataOdd, 32'd0);
        applyStimulus(1'b1, 4'd11, 32'h0000B0B0, 1'b0, 4'd0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd11);
        checkOutput("last_word12", dataOdd, 32'h0000B0B0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd5);
        checkOutput("no_alias12", dataOdd, 32'h12345678);

        // Back-to-back reads through the 3-stage pipeline.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 32'h100 + 32'(i), 1'b0, 4'd0);
        end
        for (int k = 1; k <= 19; k++) begin
            if (k <= 16) applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'(k - 1));
            else         applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
            checkOutput($sformatf("pipe3_ready_%0d", k), {31'd0, ready3}, (k >= 3 && k <= 18) ? 32'd1 : 32'd0);
            if (k >= 3 && k <= 18) checkOutput($sformatf("pipe3_data_%0d", k), data3, 32'h100 + 32'(k - 3));
            if (k <= 16) checkOutput($sformatf("pipe1_data_%0d", k), data1, 32'h100 + 32'(k - 1));
        end

        // Circular-buffer traffic with a small FIFO model on the LATENCY=1 instance.
        head = 0; tail = 0; count = 0;
        for (int n = 0; n < 1000; n++) begin
            doPush   = ($urandom_range(0, 1) == 1) && (count < 16);
            doPop    = ($urandom_range(0, 1) == 1) && (count > 0);
            pushData = $urandom;
            popExpect = expMem[head];
            applyStimulus(doPush, 4'(tail), pushData, doPop, 4'(head));
            checkOutput("wrap_ready", {31'd0, ready1}, {31'd0, doPop});
            if (doPop) begin
                checkOutput("wrap_data", data1, popExpect);
                head  = (head + 1) % 16;
                count = count - 1;
            end
            if (doPush) begin
                expMem[tail] = pushData;
                tail  = (tail + 1) % 16;
                count = count + 1;
            end
        end

        // Reset while two reads are in flight in the 3-stage pipeline.
        applyStimulus(1'b1, 4'd1, 32'h0BAD0001, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd1);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd2);
        rst = 1'b1;
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        checkOutput("midrst_ready3", {31'd0, ready3}, 32'd0);
        checkOutput("midrst_data3", data3, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
            checkOutput($sformatf("midrst_quiet_%0d", i), {31'd0, ready3}, 32'd0);
        end
`ifdef MEM_CLEAR_ON_RESET_EN
        afterReset = 32'd0;
`else
        afterReset = 32'h0BAD0001;
`endif
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd1);
        checkOutput("after_rst_ready1", {31'd0, ready1}, 32'd1);
        checkOutput("after_rst_data1", data1, afterReset);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        checkOutput("after_rst_ready3", {31'd0, ready3}, 32'd1);
        checkOutput("after_rst_data3", data3, afterReset);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_latency_ctrl.md
Name: mem_latency_ctrl

Overview:
- Single-port-pair register-file memory: one write port and one read port, DEPTH words of WIDTH bits.
- Read latency is a configurable pipeline of LATENCY cycles.
- Used as backing storage for queue/buffer structures. The owner computes the addresses (e.g. head/tail pointers); this block does no pointer management and has no full/empty logic.
- mem_ready flags the cycle in which read_data carries the result of an earlier read.

Parameters:
- DEPTH, 16, number of words; any value >= 2, need not be a power of two.
- WIDTH, 32, bits per word.
- LATENCY, 1, cycles from read_enable sampled to read_data valid; legal range 0..8.
- ADDR_W (localparam), max(1, $clog2(DEPTH)), address width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- write_enable  input  1  write request this cycle.
- read_enable  input  1  read request this cycle.
- write_addr  input  ADDR_W  write word address.
- read_addr  input  ADDR_W  read word address.
- write_data  input  WIDTH  data to write.
- mem_ready  output  1  high for one cycle per completed read; read_data is valid in that cycle.
- read_data  output  WIDTH  read result.

Behaviour:
- Interface: one clock domain. Reset is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - read_data <= 0, mem_ready <= 0.
  - All read-pipeline valid bits cleared, so any in-flight reads are discarded.
  - Writes and reads presented in the same cycle as rst are ignored.
  - Array contents are preserved unless MEM_CLEAR_ON_RESET_EN is defined.
- Write:
  - When write_enable=1 and write_addr < DEPTH, mem[write_addr] <= write_data at the rising edge.
  - Writes with write_addr >= DEPTH are dropped with no side effect.
- Read, LATENCY >= 1:
  - read_enable is sampled at edge T.
  - read_data and mem_ready are updated at edge T+LATENCY-1, so they are visible during cycle T+LATENCY-1..T+LATENCY. For LATENCY=1, they are registered at the same edge that samples the request.
  - Fully pipelined: one read accepted every cycle, never stalls.
  - Results return in issue order.
- Read, LATENCY = 0:
  - read_data = mem[read_addr] combinationally; mem_ready = read_enable.
- Write-first collision: for LATENCY >= 1, a read and a write to the same address in the same cycle return the new write_data.
- Out-of-range read (read_addr >= DEPTH): completes normally with mem_ready=1 and read_data=0.
- Idle cycles: read_data holds its last value; mem_ready=0 in every cycle without a completing read.
- Simultaneous read and write to different addresses are independent.
- Reset asserted mid-pipeline: no mem_ready pulse emerges for reads issued before the reset.
- No back-pressure: the consumer must accept data when mem_ready=1.

Optional Feature:
- Macro: MEM_CLEAR_ON_RESET_EN.
- Defined: every word of the array is cleared to 0 on the reset edge. A read after reset with no intervening write returns 0.
- Undefined: array has no reset, which allows RAM inference. Contents survive reset and are X before the first write in simulation.

Test Plan:
- Reset: hold rst=1 for 2 cycles with read_enable=1 -> mem_ready=0, read_data=0 throughout and in the first cycle after reset.
- Basic read, LATENCY=1: write 0xDEADBEEF to addr 3; next cycle read addr 3 -> mem_ready=1 and read_data=0xDEADBEEF one edge later; following idle cycle mem_ready=0 and read_data holds 0xDEADBEEF.
- Collision: same cycle, write 0x12345678 to addr 5 and read addr 5 -> read_data=0x12345678 (write-first).
- Pipelining, LATENCY=3: fill addr 0..15 with value 0x100+i, then read addr 0..15 back-to-back -> 16 consecutive mem_ready pulses starting 3 cycles after the first read, data 0x100..0x10F in order.
- Pointer wrap, DEPTH=16: 1000 random pushes/pops with circular tail/head pointers (mod 16), read one cycle after data is written -> every read matches the write at that slot, zero mismatches.
- Reset mid-flight, LATENCY=3: issue reads to addr 1 and 2, assert rst on the next edge -> no mem_ready pulse afterwards. With MEM_CLEAR_ON_RESET_EN, a subsequent read of addr 1 returns 0.
